// File: rtl/perf_pkg.sv
// perf_pkg
// Shared constants and types for the performance counter bank.
// Each counter owns a four-word register group (lo, hi, sel, ctrl).
// Two global words follow the last group (freeze, ovf status).
package perf_pkg;

  // Word offsets inside one counter's register group
  localparam int OFF_LO   = 0;
  localparam int OFF_HI   = 1;
  localparam int OFF_SEL  = 2;
  localparam int OFF_CTRL = 3;

  // Bit positions inside the ctrl word
  localparam int CTRL_INHIBIT_BIT = 0;
  localparam int CTRL_OVF_BIT     = 1;
  localparam int CTRL_OVF_IE_BIT  = 2;

  // Global register offsets, relative to 4*NUM_CNT
  localparam int GLB_FREEZE_OFF = 0;
  localparam int GLB_OVF_OFF    = 1;

  // Packed so that the struct lines up bit-for-bit with the ctrl word
  typedef struct packed {
    logic ovf_ie;
    logic ovf;
    logic inhibit;
  } ctrl_t;

endpackage

// File: rtl/perf_counter.sv
// perf_counter
// One counter of the bank: holds the value, applies increments with
// wrap-around, accepts half-word writes, and keeps the sticky overflow flag.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   inc       increment request for this cycle (event/inhibit/freeze resolved)
//   wr_lo     replace value[31:0] with wdata
//   wr_hi     replace value[CNT_W-1:32] with the low bits of wdata
//   wdata     write data
//   ovf_clr   write-1-to-clear of the overflow flag
//   value     current counter value
//   ovf       sticky overflow flag
module perf_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  logic bump;
  logic wrap;

  // A value write always wins; the event for that cycle is lost.
  assign bump = inc & ~wr_lo & ~wr_hi;
  assign wrap = bump & (&value);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      ovf   <= 1'b0;
    end else begin
      if (wr_lo) begin
        value[31:0] <= wdata;
      end else if (wr_hi) begin
        value[CNT_W-1:32] <= wdata[CNT_W-33:0];
      end else if (bump) begin
        value <= value + CNT_W'(1);
      end
      // Setting on wrap wins over a simultaneous clear so no overflow is lost.
      if (wrap) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank
// Bank of NUM_CNT performance counters, each counting one selectable event.
// Register access is a request/response port; reads answer one cycle later.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   events      per-cycle event pulses
//   req_valid   register access request
//   req_we      1 = write, 0 = read
//   req_addr    register address
//   req_wdata   write data
//   rsp_valid   read data valid (one cycle after a read request)
//   rsp_rdata   read data, held while rsp_valid is low
//   ovf_irq     registered OR of (ovf & ovf_ie) over all counters
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter  int NUM_CNT = 4,
  parameter  int NUM_EVT = 8,
  parameter  int CNT_W   = 64,
  localparam int ADDR_W  = $clog2(NUM_CNT*4+2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] events,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               ovf_irq
);

  logic [31:0]        addr_ext;
  logic [31:0]        cnt_idx;
  logic [1:0]         off;
  logic               is_cnt;
  logic               is_freeze;
  logic               is_ovf_stat;
  logic               wr_en;
  logic               rd_en;
  logic [31:0]        evt_pad;

  logic [CNT_W-1:0]   value [NUM_CNT];
  logic [4:0]         sel   [NUM_CNT];
  logic [NUM_CNT-1:0] ovf;
  logic [NUM_CNT-1:0] inhibit;
  logic [NUM_CNT-1:0] ovf_ie;
  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] wr_lo;
  logic [NUM_CNT-1:0] wr_hi;
  logic [NUM_CNT-1:0] wr_sel;
  logic [NUM_CNT-1:0] wr_ctrl;
  logic               freeze;

  logic [31:0]        shadow_hi;
  logic               shadow_valid;
  logic [3:0]         shadow_idx;

  logic [31:0]        rd_data;
  logic [31:0]        rd_hi_live;
  ctrl_t              rd_ctrl;

  assign addr_ext    = 32'(req_addr);
  assign cnt_idx     = {2'b00, addr_ext[31:2]};
  assign off         = addr_ext[1:0];
  assign is_cnt      = addr_ext < 32'(4*NUM_CNT);
  assign is_freeze   = addr_ext == 32'(4*NUM_CNT + GLB_FREEZE_OFF);
  assign is_ovf_stat = addr_ext == 32'(4*NUM_CNT + GLB_OVF_OFF);
  assign wr_en       = req_valid & req_we;
  assign rd_en       = req_valid & ~req_we;

  // Zero padding to 32 bits makes any sel >= NUM_EVT pick a constant 0,
  // so such a counter simply never advances.
  assign evt_pad = 32'(events);

  // Write decode into per-counter strobes
  always_comb begin
    wr_lo   = '0;
    wr_hi   = '0;
    wr_sel  = '0;
    wr_ctrl = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (wr_en && is_cnt && cnt_idx == 32'(i)) begin
        case (off)
          2'(OFF_LO):   wr_lo[i]   = 1'b1;
          2'(OFF_HI):   wr_hi[i]   = 1'b1;
          2'(OFF_SEL):  wr_sel[i]  = 1'b1;
          default:      wr_ctrl[i] = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    inc = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      inc[i] = evt_pad[sel[i]] & ~inhibit[i] & ~freeze;
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc[g]),
      .wr_lo   (wr_lo[g]),
      .wr_hi   (wr_hi[g]),
      .wdata   (req_wdata),
      .ovf_clr (wr_ctrl[g] & req_wdata[CTRL_OVF_BIT]),
      .value   (value[g]),
      .ovf     (ovf[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        sel[i] <= 5'(i % NUM_EVT);
      end
      inhibit <= '0;
      ovf_ie  <= '0;
      freeze  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (wr_sel[i]) begin
          sel[i] <= req_wdata[4:0];
        end
        if (wr_ctrl[i]) begin
          inhibit[i] <= req_wdata[CTRL_INHIBIT_BIT];
          ovf_ie[i]  <= req_wdata[CTRL_OVF_IE_BIT];
        end
      end
      if (wr_en && is_freeze) begin
        freeze <= req_wdata[0];
      end
    end
  end

  // Read mux; values are the pre-increment state of this cycle.
  always_comb begin
    rd_data    = '0;
    rd_hi_live = '0;
    rd_ctrl    = '0;
    if (is_cnt) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (cnt_idx == 32'(i)) begin
          rd_hi_live      = 32'(value[i][CNT_W-1:32]);
          rd_ctrl.ovf_ie  = ovf_ie[i];
          rd_ctrl.ovf     = ovf[i];
          rd_ctrl.inhibit = inhibit[i];
          case (off)
            2'(OFF_LO):  rd_data = value[i][31:0];
            2'(OFF_HI):  rd_data = (shadow_valid && shadow_idx == 4'(i)) ?
                                   shadow_hi : rd_hi_live;
            2'(OFF_SEL): rd_data = 32'(sel[i]);
            default:     rd_data = 32'(rd_ctrl);
          endcase
        end
      end
    end else if (is_freeze) begin
      rd_data = 32'(freeze);
    end else if (is_ovf_stat) begin
      rd_data = 32'(ovf);
    end
  end

  // Shadow of the high word: armed by a lo read, consumed only by the very
  // next read, and dropped by any write into the same counter's group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_hi    <= '0;
      shadow_valid <= 1'b0;
      shadow_idx   <= '0;
    end else if (rd_en) begin
      if (is_cnt && off == 2'(OFF_LO)) begin
        shadow_hi    <= rd_hi_live;
        shadow_valid <= 1'b1;
        shadow_idx   <= 4'(cnt_idx);
      end else begin
        shadow_valid <= 1'b0;
      end
    end else if (wr_en && is_cnt && 4'(cnt_idx) == shadow_idx) begin
      shadow_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ovf_irq   <= 1'b0;
    end else begin
      rsp_valid <= rd_en;
      if (rd_en) begin
        rsp_rdata <= rd_data;
      end
      ovf_irq <= |(ovf & ovf_ie);
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank
// Directed bench for perf_counter_bank. Read requests push their expected
// data into a queue; a monitor on the falling edge pops and compares each
// response as it appears.
module tb_perf_counter_bank;

  localparam int NUM_CNT = 4;
  localparam int NUM_EVT = 8;
  localparam int CNT_W   = 64;
  localparam int ADDR_W  = $clog2(NUM_CNT*4+2);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_EVT-1:0] events = '0;
  logic               req_valid = 1'b0;
  logic               req_we = 1'b0;
  logic [ADDR_W-1:0]  req_addr = '0;
  logic [31:0]        req_wdata = '0;
  logic               rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               ovf_irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q  [$];
  string       name_q [$];
  logic [31:0] mon_exp;
  string       mon_name;

  perf_counter_bank #(
    .NUM_CNT (NUM_CNT),
    .NUM_EVT (NUM_EVT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .events    (events),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ovf_irq   (ovf_irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = ADDR_W'(addr);
    req_wdata = data;
    step();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic rd(input string name, input int addr, input logic [31:0] exp);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = ADDR_W'(addr);
    exp_q.push_back(exp);
    name_q.push_back(name);
    step();
    req_valid = 1'b0;
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_rsp: got 0x%08h expected no response", rsp_rdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        checkOutput(mon_name, rsp_rdata, mon_exp);
      end
    end
  end

  task automatic applyStimulus();
    // Reset state
    #2;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_ovf_irq", 32'(ovf_irq), 32'd0);

    // Cycle counting on counter 0
    events = 8'h01;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (100) step();
    rd("cnt0_lo_100", 0, 32'd100);
    rd("cnt0_hi_0", 1, 32'd0);
    events = 8'h00;
    rd("cnt0_lo_held", 0, 32'd102);

    // Wrap of counter 1 with interrupt
    wr(4, 32'hFFFF_FFFE);
    wr(5, 32'hFFFF_FFFF);
    wr(7, 32'h4);
    events = 8'h02;
    step();
    step();
    checkOutput("irq_not_yet", 32'(ovf_irq), 32'd0);
    step();
    checkOutput("irq_after_wrap", 32'(ovf_irq), 32'd1);
    events = 8'h00;
    rd("cnt1_lo_1", 4, 32'd1);
    rd("cnt1_hi_0", 5, 32'd0);
    rd("cnt1_ctrl", 7, 32'h6);
    rd("ovf_status", 17, 32'h2);
    wr(7, 32'h6);
    step();
    checkOutput("irq_cleared", 32'(ovf_irq), 32'd0);
    rd("ovf_status_clr", 17, 32'h0);

    // Coherent 64-bit read across a carry
    wr(0, 32'hFFFF_FFFF);
    events = 8'h01;
    rd("coh_lo", 0, 32'hFFFF_FFFF);
    rd("coh_hi_shadow", 1, 32'd0);
    rd("coh_hi_live", 1, 32'd1);
    events = 8'h00;

    // Inhibit
    wr(11, 32'h1);
    events = 8'h04;
    repeat (10) step();
    events = 8'h00;
    rd("inhibit_cnt2", 8, 32'd0);
    wr(11, 32'h0);

    // Freeze
    wr(16, 32'h1);
    events = 8'h0F;
    repeat (10) step();
    rd("freeze_cnt2", 8, 32'd0);
    rd("freeze_cnt1", 4, 32'd1);
    rd("freeze_reg", 16, 32'd1);
    events = 8'h04;
    wr(16, 32'h0);
    repeat (5) step();
    events = 8'h00;
    rd("resume_cnt2", 8, 32'd5);

    // Write beats increment
    events = 8'h01;
    wr(0, 32'h10);
    rd("collision_lo", 0, 32'h10);
    events = 8'h00;

    // W1C in the wrap cycle: set wins
    wr(4, 32'hFFFF_FFFF);
    wr(5, 32'hFFFF_FFFF);
    events = 8'h02;
    wr(7, 32'h6);
    events = 8'h00;
    rd("w1c_wrap_ctrl", 7, 32'h6);
    rd("w1c_wrap_lo", 4, 32'd0);
    checkOutput("w1c_wrap_irq", 32'(ovf_irq), 32'd1);

    // Out-of-range select
    wr(14, 32'd31);
    events = 8'hFF;
    repeat (5) step();
    events = 8'h00;
    rd("sel31_cnt3", 12, 32'd0);
    rd("sel31_readback", 14, 32'd31);
    step();
    checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("hold_rsp_rdata", rsp_rdata, 32'd31);
    rd("unmapped", 18, 32'd0);
    rd("ovf_status_set", 17, 32'h2);

    // Reset in the middle of a pending response
    checkOutput("pre_reset_irq", 32'(ovf_irq), 32'd1);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = ADDR_W'(0);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("mid_reset_irq", 32'(ovf_irq), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd("post_reset_cnt1", 4, 32'd0);
    rd("post_reset_ctrl1", 7, 32'd0);
    rd("post_reset_sel3", 14, 32'd3);
    rd("post_reset_cnt0", 0, 32'd0);
  endtask

  initial begin
    applyStimulus();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      step();
    end
    while (exp_q.size() != 0) begin
      total++;
      bad++;
      mon_name = name_q.pop_front();
      mon_exp  = exp_q.pop_front();
      $display("[TB] FAIL %s: got no response expected 0x%08h", mon_name, mon_exp);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
